// File: rtl/alu_pkg.sv
// Shared constants, entry struct and mode decode for the ALU writeback slice.
package alu_pkg;
  localparam int DW = 4;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] ADC  = 4'b0001;
  localparam logic [3:0] SUB  = 4'b0010;
  localparam logic [3:0] SBB  = 4'b0011;
  localparam logic [3:0] SHL  = 4'b0100;
  localparam logic [3:0] SHR  = 4'b0101;
  localparam logic [3:0] AND  = 4'b0110;
  localparam logic [3:0] OR   = 4'b0111;
  localparam logic [3:0] NOT  = 4'b1000;
  localparam logic [3:0] XOR  = 4'b1001;
  localparam logic [3:0] NAND = 4'b1010;
  localparam logic [3:0] NOR  = 4'b1011;

  localparam int FLAG_C  = 0;
  localparam int FLAG_B  = 1;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_LT = 3;

  typedef struct packed {
    logic [3:0]    mode;
    logic          we;
    logic [DW-1:0] result;
    logic [3:0]    flags;
  } wb_entry_t;

  function automatic logic mode_is_valid(input logic [3:0] mode);
    return mode <= NOR;
  endfunction
endpackage

// File: rtl/alu_writeback_if.sv
// ALU result handshake into the writeback stage.
interface alu_writeback_if #(parameter int NREGS = 4);
  import alu_pkg::*;
  localparam int RAW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_mode;
  logic          in_we;
  logic [RAW-1:0] in_dst;
  logic [DW-1:0] in_result;
  logic [3:0]    in_flags;

  modport master (output in_valid, in_mode, in_we, in_dst, in_result, in_flags,
                  input  in_ready);
  modport slave  (input  in_valid, in_mode, in_we, in_dst, in_result, in_flags,
                  output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// NREGS x DW register file: one write port, two combinational read ports.
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [RAW-1:0] ra_sel,
  input  logic [RAW-1:0] rb_sel,
  output logic [DW-1:0]  ra,
  output logic [DW-1:0]  rb
);
  logic [NREGS-1:0][DW-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (we && waddr == RAW'(i)) mem[i] <= wdata;
    end
  end

  assign ra = mem[ra_sel];
  assign rb = mem[rb_sel];
endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: one-entry pending register, masked flag commit, register file.
// ALU_WB_FORWARD_EN: bypass the pending entry onto read ports and flag outputs.
module alu_writeback
  import alu_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst,
  alu_writeback_if.slave in_if,
  input  logic           stall,
  input  logic [RAW-1:0] rd_a_sel,
  input  logic [RAW-1:0] rd_b_sel,
  output logic [DW-1:0]  rd_a,
  output logic [DW-1:0]  rd_b,
  output logic           carry_f,
  output logic           borrow_f,
  output logic           zero_f,
  output logic           lt_f,
  output logic           illegal,
  output logic           commit
);
  wb_entry_t      pend;
  logic [RAW-1:0] pend_dst;
  logic           pend_valid;
  logic           pend_ok;
  logic           accept;
  logic           rf_we;
  logic [3:0]     flags_q, flags_nxt;
  logic [DW-1:0]  rf_a, rf_b;

  assign in_if.in_ready = !pend_valid || !stall;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign commit         = pend_valid && !stall;
  assign pend_ok        = pend_valid && mode_is_valid(pend.mode);
  assign rf_we          = commit && pend_ok && pend.we;

  // Carry/borrow raw bits are only driven by the ALU in ADC/SBB.
  always_comb begin
    flags_nxt = flags_q;
    if (pend_ok) begin
      flags_nxt[FLAG_Z]  = pend.flags[FLAG_Z];
      flags_nxt[FLAG_LT] = pend.flags[FLAG_LT];
      if (pend.mode == ADC) flags_nxt[FLAG_C] = pend.flags[FLAG_C];
      if (pend.mode == SBB) flags_nxt[FLAG_B] = pend.flags[FLAG_B];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      pend_dst   <= '0;
      pend_valid <= 1'b0;
      flags_q    <= '0;
      illegal    <= 1'b0;
    end else begin
      if (accept) begin
        pend     <= '{mode: in_if.in_mode, we: in_if.in_we,
                      result: in_if.in_result, flags: in_if.in_flags};
        pend_dst <= in_if.in_dst;
      end
      // Commit and capture on the same edge keeps the entry occupied.
      if (accept)      pend_valid <= 1'b1;
      else if (commit) pend_valid <= 1'b0;
      if (commit) begin
        flags_q <= flags_nxt;
        if (!mode_is_valid(pend.mode)) illegal <= 1'b1;
      end
    end
  end

  alu_regfile #(.NREGS(NREGS)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (pend_dst),
    .wdata  (pend.result),
    .ra_sel (rd_a_sel),
    .rb_sel (rd_b_sel),
    .ra     (rf_a),
    .rb     (rf_b)
  );

`ifdef ALU_WB_FORWARD_EN
  assign rd_a = (pend_ok && pend.we && pend_dst == rd_a_sel) ? pend.result : rf_a;
  assign rd_b = (pend_ok && pend.we && pend_dst == rd_b_sel) ? pend.result : rf_b;
  assign {lt_f, zero_f, borrow_f, carry_f} = flags_nxt;
`else
  assign rd_a = rf_a;
  assign rd_b = rf_b;
  assign {lt_f, zero_f, borrow_f, carry_f} = flags_q;
`endif
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the 4-bit ALU.
- Captures the ALU result and raw flags into a one-entry pending register, then commits them to a small register file and an architectural flag register.
- Supplies the ALU's operands (two read ports) and its carry_f/borrow_f inputs.
- Masks the ALU's mode-dependent flag outputs so that only meaningful flag bits are committed.

Parameters:
- NREGS, 4, number of 4-bit general registers; must be a power of two, 2..8.
- RAW, $clog2(NREGS), register address width; derived, do not override.
- DW, 4, datapath width; fixed to the ALU width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result presented this cycle.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- in_mode  in  4  ALU mode that produced the result.
- in_we  in  1  result is to be written to the register file.
- in_dst  in  RAW  destination register index.
- in_result  in  DW  ALU output c.
- in_flags  in  4  raw ALU flags: [0] carry, [1] borrow, [2] zero, [3] a<b.
- stall  in  1  freezes commit of the pending entry.
- rd_a_sel, rd_b_sel  in  RAW each  read port selects.
- rd_a, rd_b  out  DW each  read data, feeding ALU a/b.
- carry_f, borrow_f, zero_f, lt_f  out  1 each  architectural flags.
- illegal  out  1  sticky; set when an invalid mode is committed.
- commit  out  1  one-cycle pulse when the pending entry commits.

Behaviour:
- Reset (async):
  - All registers = 0; all flags = 0.
  - pend_valid = 0, illegal = 0, commit = 0.
  - Any pending entry is discarded; nothing is committed.
- Pipeline:
  - Capture: on an accepted transfer, store mode/we/dst/result/flags in the pending register and set pend_valid.
  - Commit: in the cycle where pend_valid && !stall, the pending entry commits at that clock edge and commit pulses high for that cycle.
  - Latency: accept at edge N, architectural state visible after edge N+1 (stall = 0).
- Ready and overlap:
  - in_ready = !pend_valid || !stall.
  - A simultaneous commit and capture is allowed: the old entry commits and the new entry loads on the same edge, giving full throughput.
  - While stalled with pend_valid = 1, in_ready = 0 and the entry is held unchanged.
- Commit rules, valid mode (0000-1011):
  - If we = 1, write result to reg[dst].
  - zero_f and lt_f always take the captured bits [2] and [3].
  - carry_f updates only when mode == 0001.
  - borrow_f updates only when mode == 0011.
  - Otherwise carry_f and borrow_f hold their values. The ALU drives bits [0]/[1] only in those modes, so they are undefined in every other mode.
- Commit rules, invalid mode (1100-1111):
  - No register write and no flag update.
  - illegal is set; it clears only on reset.
- Reads:
  - Combinational from the register file; both ports may select the same register.
- Arithmetic:
  - No arithmetic in this block; all values are stored bit-exact at DW bits.

Optional Feature:
- Macro: ALU_WB_FORWARD_EN.
- Defined:
  - rd_a/rd_b return the pending result when pend_valid && we && dst matches the select and the mode is valid.
  - carry_f/borrow_f/zero_f/lt_f show the value they will take after the pending commit.
  - Back-to-back dependent ALU ops need no bubble.
- Undefined:
  - Outputs reflect committed state only; the issuer must insert a bubble.
  - in_ready is unaffected.

Decomposition:
- Package alu_pkg:
  - Mode constants: ADD=0000, ADC=0001, SUB=0010, SBB=0011, SHL=0100, SHR=0101, AND=0110, OR=0111, NOT=1000, XOR=1001, NAND=1010, NOR=1011.
  - Flag bit indices: FLAG_C=0, FLAG_B=1, FLAG_Z=2, FLAG_LT=3.
  - DW = 4 and the function mode_is_valid.
- One natural sub-module, alu_regfile: NREGS x DW storage, one write port, two combinational read ports, async reset to 0.

Test Plan:
- Reset mid-pending: accept ADD dst=2 result=5, assert rst before commit → reg2 = 0, commit never pulses, all flags 0.
- ADC with flags=0001, result=3, dst=1, then ADD with flags=0000 → after both commits carry_f = 1 (held through ADD), reg1 = 3.
- SBB with flags=0010, then AND with flags=0110 → borrow_f = 1 held, zero_f = 1, lt_f = 0.
- stall = 1 with pend_valid → in_ready = 0 and entry held 3 cycles; drop stall → single commit pulse, then back-to-back accepts each cycle.
- mode = 1110, we = 1, dst = 0, result = F → reg0 unchanged, flags unchanged, illegal = 1 until reset.
- With ALU_WB_FORWARD_EN: accept result = A to dst = 3 with rd_a_sel = 3 → rd_a = A in the cycle before commit; without the macro → old value.
